// File: rtl/puf_meas_ctrl_pkg.sv
// Shared types and constants for the RO-PUF measurement controller.
package puf_pkg;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        SETTLE,
        CAPT,
        CMP,
        DONE
    } state_t;

    // Counter clear pulse length in clk cycles
    localparam int CLR_CYC = 2;

    // Ceiling log2, used to size timers and indices at elaboration
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/puf_meas_ctrl_if.sv
// Host + RO datapath signal bundle for puf_meas_ctrl.
// PUF_MEAS_RAW_EN adds the raw count characterisation outputs.
interface puf_meas_if #(
    parameter int CNT_BIT_SIZE = 5,
    parameter int N_BITS       = 8,
    parameter int SEL_W        = 4
) ();
    logic                    i_start;
    logic [CNT_BIT_SIZE-1:0] i_count;
    logic                    o_ro_en;
    logic [SEL_W-1:0]        o_ro_sel;
    logic                    o_cnt_rst_n;
    logic                    o_busy;
    logic                    o_done;
    logic [N_BITS-1:0]       o_response;
    logic                    o_tie;

`ifdef PUF_MEAS_RAW_EN
    logic [CNT_BIT_SIZE-1:0] o_raw_a;
    logic [CNT_BIT_SIZE-1:0] o_raw_b;
    logic                    o_raw_valid;

    modport master (
        output i_start, i_count,
        input  o_ro_en, o_ro_sel, o_cnt_rst_n, o_busy, o_done, o_response, o_tie,
        input  o_raw_a, o_raw_b, o_raw_valid
    );
    modport slave (
        input  i_start, i_count,
        output o_ro_en, o_ro_sel, o_cnt_rst_n, o_busy, o_done, o_response, o_tie,
        output o_raw_a, o_raw_b, o_raw_valid
    );
`else
    modport master (
        output i_start, i_count,
        input  o_ro_en, o_ro_sel, o_cnt_rst_n, o_busy, o_done, o_response, o_tie
    );
    modport slave (
        input  i_start, i_count,
        output o_ro_en, o_ro_sel, o_cnt_rst_n, o_busy, o_done, o_response, o_tie
    );
`endif
endinterface

// File: rtl/puf_meas_ctrl_win_timer.sv
// Loadable down-counter timing the CLR/RUN/SETTLE phases.
// Loading D-1 gives o_expired in the D-th cycle after the load edge.
module puf_win_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);
    logic [W-1:0] cnt;
    logic         active;

    // Count down from the loaded value; a load always wins over expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (i_load) begin
            cnt    <= i_load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - W'(1);
        end
    end

    assign o_expired = active && (cnt == '0);

endmodule

// File: rtl/puf_meas_ctrl.sv
// RO-PUF response sequencer: measures RO pairs (2k, 2k+1) one after the other
// and compares their edge counts into response bit k.
// Optional macro PUF_MEAS_RAW_EN exposes the captured pair counts in CMP.
module puf_meas_ctrl #(
    parameter int CNT_BIT_SIZE = 5,
    parameter int N_BITS       = 8,
    parameter int SEL_W        = 4,
    parameter int WIN_CYC      = 64,
    parameter int SETTLE_CYC   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    puf_meas_if.slave bus
);
    import puf_pkg::*;

    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC)
                           ? ((WIN_CYC > CLR_CYC) ? WIN_CYC : CLR_CYC)
                           : ((SETTLE_CYC > CLR_CYC) ? SETTLE_CYC : CLR_CYC);
    localparam int TMR_W = clog2(TMR_MAX);
    localparam int IDX_W = (N_BITS > 1) ? clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

    state_t                  state, state_nx;
    logic                    tmr_load, tmr_exp;
    logic [TMR_W-1:0]        tmr_val;
    logic [IDX_W-1:0]        idx, idx_inc;
    logic                    phase_b;
    logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_b;
    logic                    ro_en, cnt_rst_n, busy, done, tie;
    logic [SEL_W-1:0]        ro_sel;
    logic [N_BITS-1:0]       response;

    assign idx_inc = idx + IDX_W'(1);

    puf_win_timer #(.W(TMR_W)) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_expired  (tmr_exp)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, plus a timer load on entry to each timed phase
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE:    if (bus.i_start) state_nx = CLR;
            CLR:     if (tmr_exp) state_nx = RUN;
            RUN:     if (tmr_exp) state_nx = SETTLE;
            SETTLE:  if (tmr_exp) state_nx = CAPT;
            CAPT:    state_nx = phase_b ? CMP : CLR;
            CMP:     state_nx = (idx == LAST_IDX) ? DONE : CLR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) begin
            case (state_nx)
                CLR:     begin tmr_load = 1'b1; tmr_val = TMR_W'(CLR_CYC - 1);    end
                RUN:     begin tmr_load = 1'b1; tmr_val = TMR_W'(WIN_CYC - 1);    end
                SETTLE:  begin tmr_load = 1'b1; tmr_val = TMR_W'(SETTLE_CYC - 1); end
                default: ;
            endcase
        end
    end

    // Control outputs registered from the next state so they are glitch-free;
    // the counter stays cleared outside RUN..CAPT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_en     <= 1'b0;
            cnt_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ro_en     <= (state_nx == RUN);
            cnt_rst_n <= (state_nx == RUN) || (state_nx == SETTLE) || (state_nx == CAPT);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
        end
    end

    // Pair bookkeeping: RO select moves only on CLR entry, while the RO is off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            phase_b  <= 1'b0;
            ro_sel   <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            response <= '0;
            tie      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        idx      <= '0;
                        phase_b  <= 1'b0;
                        ro_sel   <= '0;
                        response <= '0;
                        tie      <= 1'b0;
                    end
                end
                CAPT: begin
                    if (!phase_b) begin
                        cnt_a   <= bus.i_count;
                        phase_b <= 1'b1;
                        ro_sel  <= SEL_W'({idx, 1'b1});
                    end else begin
                        cnt_b   <= bus.i_count;
                    end
                end
                CMP: begin
                    response[idx] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) tie <= 1'b1;
                    if (idx != LAST_IDX) begin
                        idx     <= idx_inc;
                        phase_b <= 1'b0;
                        ro_sel  <= SEL_W'({idx_inc, 1'b0});
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ro_en     = ro_en;
    assign bus.o_ro_sel    = ro_sel;
    assign bus.o_cnt_rst_n = cnt_rst_n;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_response  = response;
    assign bus.o_tie       = tie;

`ifdef PUF_MEAS_RAW_EN
    // Capture registers already hold the pair; just expose them during CMP
    assign bus.o_raw_a     = cnt_a;
    assign bus.o_raw_b     = cnt_b;
    assign bus.o_raw_valid = (state == CMP);
`else
`endif

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Bench for puf_meas_ctrl: table of per-pair counts with expected response,
// plus directed sequences for mid-run reset, ignored starts and raw outputs.
module tb_puf_meas_ctrl;
    localparam int CW = 5;
    localparam int NB = 8;
    localparam int SW = 4;
    localparam int NV = 5;
    localparam int RUN_CYC = 1144;

    typedef struct packed {
        logic [NB-1:0][CW-1:0] ca;
        logic [NB-1:0][CW-1:0] cb;
        logic [NB-1:0]         resp;
        logic                  tie;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puf_meas_if #(.CNT_BIT_SIZE(CW), .N_BITS(NB), .SEL_W(SW)) bif ();

    puf_meas_ctrl #(
        .CNT_BIT_SIZE(CW), .N_BITS(NB), .SEL_W(SW), .WIN_CYC(64), .SETTLE_CYC(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Counter model: cleared while o_cnt_rst_n low, else the table count of the selected RO
    logic [CW-1:0] cnt_tbl [16];
    assign bif.i_count = bif.o_cnt_rst_n ? cnt_tbl[bif.o_ro_sel] : '0;

    int total = 0;
    int bad = 0;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // RO-select monitor: record turn-on order, flag select changes while enabled
    int sel_glitch = 0;
    logic [SW-1:0] prev_sel = '0;
    logic prev_en = 1'b0;
    int on_q [$];
    always @(negedge clk) begin
        if (rst_n && (bif.o_ro_sel !== prev_sel) && (bif.o_ro_en || prev_en)) sel_glitch++;
        if (bif.o_ro_en && !prev_en) on_q.push_back(int'(bif.o_ro_sel));
        prev_sel = bif.o_ro_sel;
        prev_en  = bif.o_ro_en;
    end

    task automatic load_tbl(input int v);
        for (int k = 0; k < NB; k++) begin
            cnt_tbl[2*k]   = vecs[v].ca[k];
            cnt_tbl[2*k+1] = vecs[v].cb[k];
        end
    endtask

    task automatic run_check(input int v, input bit inject);
        int cyc, busy_bad, extra, seq_bad;
        load_tbl(v);
        on_q.delete();
        @(negedge clk); bif.i_start = 1'b1;
        @(posedge clk); #1; bif.i_start = 1'b0;
        chk($sformatf("v%0d_busy_on", v), bif.o_busy, 1);
        chk($sformatf("v%0d_resp_clr", v), bif.o_response, 0);
        chk($sformatf("v%0d_tie_clr", v), bif.o_tie, 0);
        cyc = 0;
        busy_bad = 0;
        while (cyc < 2000) begin
            @(posedge clk); cyc++; #1;
            if (bif.o_done) begin
                bif.i_start = inject;
                break;
            end
            if (!bif.o_busy) busy_bad++;
            bif.i_start = inject && (cyc == 100);
        end
        chk($sformatf("v%0d_done_cyc", v), cyc, RUN_CYC);
        chk($sformatf("v%0d_busy_hold", v), busy_bad, 0);
        chk($sformatf("v%0d_busy_in_done", v), bif.o_busy, 1);
        @(posedge clk); #1; bif.i_start = 1'b0;
        chk($sformatf("v%0d_done_pulse", v), bif.o_done, 0);
        chk($sformatf("v%0d_busy_off", v), bif.o_busy, 0);
        extra = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (bif.o_done || bif.o_busy) extra++;
        end
        chk($sformatf("v%0d_stay_idle", v), extra, 0);
        chk($sformatf("v%0d_resp", v), bif.o_response, vecs[v].resp);
        chk($sformatf("v%0d_tie", v), bif.o_tie, vecs[v].tie);
        seq_bad = 0;
        if (on_q.size() != 2*NB) seq_bad = 100 + on_q.size();
        else for (int i = 0; i < 2*NB; i++) if (on_q[i] != i) seq_bad++;
        chk($sformatf("v%0d_ro_sel_seq", v), seq_bad, 0);
    endtask

    initial begin
        bif.i_start = 1'b0;
        for (int i = 0; i < 16; i++) cnt_tbl[i] = '0;

        // v0: A>B everywhere; v1: A<B with pair 3 tied; v2: alternating;
        // v3: extremes at pairs 0/7, ties elsewhere; v4: ramp against 14
        for (int k = 0; k < NB; k++) begin
            vecs[0].ca[k] = 5'd20;  vecs[0].cb[k] = 5'd10;
            vecs[1].ca[k] = (k == 3) ? 5'd7 : 5'd5;
            vecs[1].cb[k] = (k == 3) ? 5'd7 : 5'd9;
            vecs[2].ca[k] = (k % 2 == 0) ? 5'd15 : 5'd3;
            vecs[2].cb[k] = (k % 2 == 0) ? 5'd8  : 5'd11;
            vecs[3].ca[k] = (k == 0) ? 5'd0  : (k == 7) ? 5'd31 : 5'd16;
            vecs[3].cb[k] = (k == 0) ? 5'd31 : (k == 7) ? 5'd0  : 5'd16;
            vecs[4].ca[k] = CW'(4 * k);
            vecs[4].cb[k] = 5'd14;
        end
        vecs[0].resp = 8'hFF; vecs[0].tie = 1'b0;
        vecs[1].resp = 8'h00; vecs[1].tie = 1'b1;
        vecs[2].resp = 8'h55; vecs[2].tie = 1'b0;
        vecs[3].resp = 8'h80; vecs[3].tie = 1'b1;
        vecs[4].resp = 8'hF0; vecs[4].tie = 1'b0;

        #2;
        chk("rst_ro_en", bif.o_ro_en, 0);
        chk("rst_ro_sel", bif.o_ro_sel, 0);
        chk("rst_cnt_rst_n", bif.o_cnt_rst_n, 0);
        chk("rst_busy", bif.o_busy, 0);
        chk("rst_done", bif.o_done, 0);
        chk("rst_resp", bif.o_response, 0);
        chk("rst_tie", bif.o_tie, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", bif.o_busy, 0);
        chk("idle_ro_en", bif.o_ro_en, 0);

        for (int v = 0; v < NV; v++) run_check(v, 1'b0);

        // Starts during the run and in the DONE cycle must be ignored
        run_check(2, 1'b1);
        chk("ro_sel_glitch", sel_glitch, 0);

        // Reset 30 cycles into a run (inside the RUN window)
        load_tbl(0);
        @(negedge clk); bif.i_start = 1'b1;
        @(posedge clk); #1; bif.i_start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_ro_en_before", bif.o_ro_en, 1);
        chk("mid_cnt_rst_n_before", bif.o_cnt_rst_n, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ro_en", bif.o_ro_en, 0);
        chk("mid_rst_cnt_rst_n", bif.o_cnt_rst_n, 0);
        chk("mid_rst_busy", bif.o_busy, 0);
        chk("mid_rst_resp", bif.o_response, 0);
        chk("mid_rst_sel", bif.o_ro_sel, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef PUF_MEAS_RAW_EN
        begin
            int rcyc;
            for (int i = 0; i < 16; i++) cnt_tbl[i] = '0;
            cnt_tbl[0] = 5'd12;
            cnt_tbl[1] = 5'd3;
            @(negedge clk); bif.i_start = 1'b1;
            @(posedge clk); #1; bif.i_start = 1'b0;
            rcyc = 0;
            while (rcyc < 500 && !bif.o_raw_valid) begin
                @(posedge clk); rcyc++; #1;
            end
            chk("raw_valid_cyc", rcyc, 142);
            chk("raw_a", bif.o_raw_a, 12);
            chk("raw_b", bif.o_raw_b, 3);
            @(posedge clk); #1;
            chk("raw_valid_pulse", bif.o_raw_valid, 0);
            rcyc = 0;
            while (rcyc < 2000 && !bif.o_done) begin
                @(posedge clk); rcyc++; #1;
            end
            chk("raw_run_done", bif.o_done, 1);
            chk("raw_resp", bif.o_response, 8'h01);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
